// File: rtl/div_if.sv
// Request/response bundle between a divide requester (master) and div_seq (slave).
interface div_if;
  localparam int unsigned DW = 32;

  logic              signed_div_i;
  logic [DW-1:0]     opdata1_i;
  logic [DW-1:0]     opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [2*DW-1:0]   result_o;
  logic              ready_o;
  logic              busy_o;
  logic              divzero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o, divzero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o, divzero_o
  );
endinterface

// File: rtl/div_seq.sv
// 32/32 sequential restoring divider, signed or unsigned, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: short-circuit requests whose divisor magnitude exceeds the dividend's.
module div_seq (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_STEP = CW'(DW);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*DW:0]     work_q;
  logic [DW-1:0]     divisor_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [2*DW-1:0]   result_q;
  logic              ready_q;
  logic              divzero_q;
`ifdef DIV_EARLY_OUT_EN
  logic              early_q;
  logic [DW-1:0]     dividend_q;
`endif

  logic              a_neg;
  logic              b_neg;
  logic [DW-1:0]     a_mag;
  logic [DW-1:0]     b_mag;
  logic [DW+1:0]     trial;
  logic [2*DW:0]     work_d;
  logic [DW-1:0]     quo_fix;
  logic [DW-1:0]     rem_fix;

  // Operand magnitudes, one restoring step, and the final sign fix-up.
  // work_q = {partial remainder [2DW:DW], unshifted dividend bits / quotient bits [DW-1:0]}.
  always_comb begin
    a_neg   = bus.signed_div_i & bus.opdata1_i[DW-1];
    b_neg   = bus.signed_div_i & bus.opdata2_i[DW-1];
    a_mag   = a_neg ? DW'(~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    b_mag   = b_neg ? DW'(~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    trial   = work_q[2*DW:DW-1] - {2'b00, divisor_q};
    work_d  = trial[DW+1] ? {work_q[2*DW-1:0], 1'b0}
                          : {trial[DW:0], work_q[DW-2:0], 1'b1};
    quo_fix = neg_quo_q ? DW'(~work_q[DW-1:0] + 1'b1) : work_q[DW-1:0];
    rem_fix = neg_rem_q ? DW'(~work_q[2*DW-1:DW] + 1'b1) : work_q[2*DW-1:DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      divzero_q  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      early_q    <= 1'b0;
      dividend_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            cnt_q     <= '0;
            work_q    <= {{(DW+1){1'b0}}, a_mag};
            divisor_q <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
`ifdef DIV_EARLY_OUT_EN
            early_q    <= 1'b0;
            dividend_q <= bus.opdata1_i;
            if (bus.opdata2_i == '0) begin
              state_q <= BYZERO;
            end else if (b_mag > a_mag) begin
              early_q <= 1'b1;
              state_q <= BYZERO;
            end else begin
              state_q <= ON;
            end
`else
            if (bus.opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              state_q <= ON;
            end
`endif
          end
        end

        // Two-edge path: divide-by-zero, or the early-out shortcut when enabled.
        BYZERO: begin
          if (bus.annul_i) begin
            state_q <= IDLE;
          end else begin
            state_q <= END;
            ready_q <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (early_q) begin
              result_q  <= {dividend_q, {DW{1'b0}}};
              divzero_q <= 1'b0;
            end else begin
              result_q  <= '0;
              divzero_q <= 1'b1;
            end
`else
            result_q  <= '0;
            divzero_q <= 1'b1;
`endif
          end
        end

        // Annul wins over completion; the final count only registers the result.
        ON: begin
          if (bus.annul_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_STEP) begin
            state_q  <= END;
            cnt_q    <= '0;
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end

        END: begin
          if (!bus.start_i) begin
            state_q   <= IDLE;
            result_q  <= '0;
            ready_q   <= 1'b0;
            divzero_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.result_o  = result_q;
  assign bus.ready_o   = ready_q;
  assign bus.divzero_o = divzero_q;
  assign bus.busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued at issue and popped when ready_o rises.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_if dif ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic [63:0] result;
    logic        divzero;
    int          lat;
  } exp_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Reference: 64-bit host arithmetic, C-style truncation; latency counted in edges incl. the accept edge.
  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, q, r, ma, mb;
    if (b == 32'd0) begin
      e.result = 64'd0; e.divzero = 1'b1; e.lat = 2;
      return e;
    end
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    e.result  = {r[31:0], q[31:0]};
    e.divzero = 1'b0;
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    e.lat = (EARLY && mb > ma) ? 2 : 34;
    return e;
  endfunction

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
  endtask

  task automatic wait_ready(output logic ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (dif.ready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.annul_i = 1'b0;
    drive(1'b0, 32'd10, 32'd3);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dif.ready_o, dif.divzero_o, dif.busy_o} !== 3'b000 || dif.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b dz=%b busy=%b res=%h, want all 0",
               dif.ready_o, dif.divzero_o, dif.busy_o, dif.result_o);
    end
    dif.start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dif.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b want 0", dif.busy_o);
    end
  endtask

  task automatic test_spec_vectors();
    vec_t v[6];
    exp_t e;
    logic ok;
    int   lat;
    v[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0, 34};
    v[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
    v[2] = '{1'b0, 32'd1234,       32'd0,        64'd0,                 1'b1, 2};
    v[3] = '{1'b1, 32'h80000000,   32'd0,        64'd0,                 1'b1, 2};
    v[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
    v[5] = '{1'b0, 32'd5,          32'd9,        64'h00000005_00000000, 1'b0, EARLY ? 2 : 34};
    foreach (v[i]) begin
      exp_q.push_back('{v[i].res, v[i].dz, v[i].lat});
      drive(v[i].sgn, v[i].a, v[i].b);
      wait_ready(ok, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL spec%0d_timeout: ready_o low after %0d cycles, want high", i, lat);
      end else begin
        n_cmp += 3;
        if (dif.result_o !== e.result) begin
          n_fail++;
          $display("FAIL spec%0d_result: got %h want %h", i, dif.result_o, e.result);
        end
        if (dif.divzero_o !== e.divzero) begin
          n_fail++;
          $display("FAIL spec%0d_divzero: got %b want %b", i, dif.divzero_o, e.divzero);
        end
        if (lat !== e.lat) begin
          n_fail++;
          $display("FAIL spec%0d_latency: got %0d want %0d", i, lat, e.lat);
        end
      end
      dif.start_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({dif.ready_o, dif.divzero_o, dif.busy_o} !== 3'b000 || dif.result_o !== 64'd0) begin
        n_fail++;
        $display("FAIL spec%0d_release: got rdy=%b dz=%b busy=%b res=%h, want all 0",
                 i, dif.ready_o, dif.divzero_o, dif.busy_o, dif.result_o);
      end
    end
  endtask

  // Random operands, each issued on the cycle the previous one returned to IDLE.
  task automatic test_back_to_back();
    exp_t        e;
    logic        ok, sgn;
    int          lat;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom >> $urandom_range(0, 31);
      b   = $urandom >> $urandom_range(0, 31);
      if (i == 4) b = 32'd0;
      if (i == 7) begin sgn = 1'b1; a = 32'h80000000; b = 32'd3; end
      if (i == 9) begin sgn = 1'b1; a = 32'h00000011; b = 32'hFFFFFFF0; end
      exp_q.push_back(model(sgn, a, b));
      drive(sgn, a, b);
      wait_ready(ok, lat);
      e = exp_q.pop_front();
      n_cmp++;
      if (ok !== 1'b1 || dif.result_o !== e.result || dif.divzero_o !== e.divzero || lat !== e.lat) begin
        n_fail++;
        $display("FAIL b2b%0d: sgn=%b a=%h b=%h got rdy=%b res=%h dz=%b lat=%0d want res=%h dz=%b lat=%0d",
                 i, sgn, a, b, ok, dif.result_o, dif.divzero_o, lat, e.result, e.divzero, e.lat);
      end
      dif.start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_annul();
    exp_t e;
    logic ok;
    int   lat, seen;
    drive(1'b0, 32'd1000, 32'd3);
    repeat (11) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    n_cmp++;
    if ({dif.ready_o, dif.busy_o} !== 2'b00 || dif.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL annul_on: got rdy=%b busy=%b res=%h, want 0/0/0",
               dif.ready_o, dif.busy_o, dif.result_o);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL annul_no_ready: ready_o high on %0d cycles, want 0", seen);
    end
    exp_q.push_back('{64'h00000000_00000003, 1'b0, 34});
    drive(1'b0, 32'd9, 32'd3);
    wait_ready(ok, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || dif.result_o !== e.result || lat !== e.lat) begin
      n_fail++;
      $display("FAIL annul_next: got rdy=%b res=%h lat=%0d want res=%h lat=%0d",
               ok, dif.result_o, lat, e.result, e.lat);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
    // Annul while in BYZERO.
    drive(1'b0, 32'd77, 32'd0);
    @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    n_cmp++;
    if ({dif.ready_o, dif.divzero_o, dif.busy_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL annul_byzero: got rdy=%b dz=%b busy=%b, want 000",
               dif.ready_o, dif.divzero_o, dif.busy_o);
    end
  endtask

  task automatic test_annul_end();
    exp_t e;
    logic ok;
    int   lat;
    exp_q.push_back(model(1'b0, 32'd100, 32'd7));
    drive(1'b0, 32'd100, 32'd7);
    wait_ready(ok, lat);
    e = exp_q.pop_front();
    dif.annul_i = 1'b1;
    dif.opdata1_i = 32'd55;
    repeat (2) @(negedge clk);
    dif.annul_i = 1'b0;
    n_cmp++;
    if (ok !== 1'b1 || dif.ready_o !== 1'b1 || dif.result_o !== e.result) begin
      n_fail++;
      $display("FAIL annul_end_hold: got rdy=%b res=%h want rdy=1 res=%h",
               dif.ready_o, dif.result_o, e.result);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic ok;
    int   lat;
    drive(1'b0, 32'd1000, 32'd3);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({dif.ready_o, dif.divzero_o, dif.busy_o} !== 3'b000 || dif.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b dz=%b busy=%b res=%h, want all 0",
               dif.ready_o, dif.divzero_o, dif.busy_o, dif.result_o);
    end
    exp_q.push_back(model(1'b1, 32'hFFFFFF9C, 32'd7));
    drive(1'b1, 32'hFFFFFF9C, 32'd7);
    wait_ready(ok, lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (ok !== 1'b1 || dif.result_o !== e.result || lat !== e.lat) begin
      n_fail++;
      $display("FAIL reset_recover: got rdy=%b res=%h lat=%0d want res=%h lat=%0d",
               ok, dif.result_o, lat, e.result, e.lat);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_annul();
    test_annul_end();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
